// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and default constants for the memory arbiter.
//   state_e  : arbiter FSM states (IDLE / REQ / WAIT)
//   owner_e  : which requester owns the outstanding transaction
//   DEF_*    : default parameter values for mem_arbiter
package mem_arb_pkg;

    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TIMEOUT = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: winner selection between fetch (IF) and load/store (LS).
//   if_req, ls_req : pending requests
//   last_win       : requester granted most recently
//   winner         : selected requester (meaningful when valid=1)
//   valid          : at least one request present
// Build option: define MEM_ARB_RR_EN for round-robin on simultaneous
// requests; otherwise LS has fixed priority and last_win is ignored.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic   if_req,
    input  logic   ls_req,
    input  owner_e last_win,
    output owner_e winner,
    output logic   valid
);

`ifdef MEM_ARB_RR_EN
    always_comb begin
        valid  = if_req | ls_req;
        winner = OWN_IF;
        if (if_req && ls_req)
            winner = (last_win == OWN_LS) ? OWN_IF : OWN_LS;
        else if (ls_req)
            winner = OWN_LS;
    end
`else
    logic unused_last;
    assign unused_last = (last_win == OWN_LS);

    always_comb begin
        valid  = if_req | ls_req;
        winner = ls_req ? OWN_LS : OWN_IF;
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates an instruction-fetch port and a load/store port
// onto one shared memory port, one transaction outstanding at a time.
//   clk, rst_n                 : clock; synchronous active-high reset
//   if_req/if_addr             : fetch read request
//   if_gnt/if_rvalid/if_rdata  : fetch grant pulse and response
//   ls_req/ls_we/ls_addr/ls_wdata/ls_be : load/store request
//   ls_gnt/ls_rvalid/ls_rdata  : load/store grant pulse and response
//   mem_req/we/addr/wdata/be   : shared memory request
//   mem_gnt/mem_rvalid/mem_rdata : memory accept and response
//   bus_err                    : pulses with a timeout response
// Build option: MEM_ARB_RR_EN selects round-robin arbitration (default is
// fixed LS priority).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                ls_req,
    input  logic                ls_we,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic [DATA_W-1:0]   ls_wdata,
    input  logic [DATA_W/8-1:0] ls_be,
    output logic                ls_gnt,
    output logic                ls_rvalid,
    output logic [DATA_W-1:0]   ls_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                bus_err
);

    localparam int BE_W  = DATA_W / 8;
    // Counter only has to reach TIMEOUT-1 (the last WAIT cycle).
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e              state, state_nxt;
    owner_e              owner, last_win, winner;
    logic                pick_vld;
    logic                grant, resp, timed_out;
    logic [DATA_W-1:0]   rsp_data;
    logic [CNT_W-1:0]    cnt;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [BE_W-1:0]     r_be;

    mem_arb_pick u_pick (
        .if_req   (if_req),
        .ls_req   (ls_req),
        .last_win (last_win),
        .winner   (winner),
        .valid    (pick_vld)
    );

    assign timed_out = (cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst_n) state <= IDLE;
        else       state <= state_nxt;
    end

    // All outputs are held low while reset is asserted so that a grant or
    // response can never be issued for a transaction that reset discards.
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        resp      = 1'b0;
        rsp_data  = '0;
        if_gnt    = 1'b0;
        ls_gnt    = 1'b0;
        if_rvalid = 1'b0;
        ls_rvalid = 1'b0;
        if_rdata  = '0;
        ls_rdata  = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        bus_err   = 1'b0;
        if (!rst_n) begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        grant     = 1'b1;
                        if_gnt    = (winner == OWN_IF);
                        ls_gnt    = (winner == OWN_LS);
                        state_nxt = REQ;
                    end
                end
                REQ: begin
                    mem_req   = 1'b1;
                    mem_we    = r_we;
                    mem_addr  = r_addr;
                    mem_wdata = r_wdata;
                    mem_be    = r_be;
                    if (mem_gnt) state_nxt = WAIT;
                end
                WAIT: begin
                    // A real response in the timeout cycle wins over the error.
                    if (mem_rvalid || timed_out) begin
                        resp      = 1'b1;
                        rsp_data  = mem_rvalid ? mem_rdata : '0;
                        bus_err   = ~mem_rvalid;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
            if (resp) begin
                if (owner == OWN_IF) begin
                    if_rvalid = 1'b1;
                    if_rdata  = rsp_data;
                end else begin
                    ls_rvalid = 1'b1;
                    ls_rdata  = rsp_data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            owner   <= OWN_IF;
            cnt     <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
        end else begin
            if (grant) begin
                owner <= winner;
                if (winner == OWN_LS) begin
                    r_we    <= ls_we;
                    r_addr  <= ls_addr;
                    r_wdata <= ls_wdata;
                    r_be    <= ls_be;
                end else begin
                    r_we    <= 1'b0;
                    r_addr  <= if_addr;
                    r_wdata <= '0;
                    r_be    <= '1;
                end
            end
            // Held at zero through REQ so it starts from zero on WAIT entry.
            if (state == WAIT) cnt <= cnt + CNT_W'(1);
            else               cnt <= '0;
        end
    end

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (rst_n)      last_win <= OWN_IF;
        else if (grant) last_win <= winner;
    end
`else
    assign last_win = OWN_IF;
`endif

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, SHALL set the address width of all address ports.
REQ-002 Parameter DATA_W, default 32, SHALL set the data width; byte-enable width SHALL be DATA_W/8.
REQ-003 Parameter TIMEOUT, default 255, SHALL set the maximum WAIT cycles before a bus error response.
REQ-004 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  SHALL be the reset: synchronous, active-high.
REQ-006 if_req  in  1; if_addr  in  ADDR_W  SHALL be the instruction-fetch read request and address.
REQ-007 if_gnt  out  1; if_rvalid  out  1; if_rdata  out  DATA_W  SHALL be the fetch grant pulse, response strobe and read data.
REQ-008 ls_req  in  1; ls_we  in  1; ls_addr  in  ADDR_W; ls_wdata  in  DATA_W; ls_be  in  DATA_W/8  SHALL be the load/store request fields.
REQ-009 ls_gnt  out  1; ls_rvalid  out  1; ls_rdata  out  DATA_W  SHALL be the load/store grant, response and data.
REQ-010 mem_req, mem_we  out  1; mem_addr  out  ADDR_W; mem_wdata  out  DATA_W; mem_be  out  DATA_W/8  SHALL drive the shared memory port.
REQ-011 mem_gnt  in  1; mem_rvalid  in  1; mem_rdata  in  DATA_W  SHALL be the memory accept, response strobe and data.
REQ-012 bus_err  out  1  SHALL pulse with the timeout response.

Function
REQ-013 FSM states SHALL be IDLE, REQ, WAIT; at most one transaction outstanding.
REQ-014 IDLE, any request present: pick winner, register its fields and owner, pulse winner's gnt one cycle, go REQ; loser's gnt SHALL stay 0.
REQ-015 Requester SHALL hold req/fields stable until its gnt; fields MAY change after gnt.
REQ-016 Fetch transactions SHALL be issued with mem_we=0 and mem_be all ones.
REQ-017 REQ: mem_req=1 with registered fields, held until mem_gnt=1, then go WAIT; mem_req SHALL be 0 in IDLE and WAIT.
REQ-018 WAIT: on mem_rvalid, owner's rvalid=1 and rdata=mem_rdata combinationally same cycle, go IDLE; writes also complete via mem_rvalid.
REQ-019 Non-owner rvalid SHALL be 0 and its rdata 0 at all times.
REQ-020 mem_rvalid in IDLE or REQ SHALL be ignored.
REQ-021 WAIT timeout counter SHALL clear on WAIT entry; after TIMEOUT cycles without mem_rvalid, owner rvalid=1, rdata=0, bus_err=1 one cycle, go IDLE.
REQ-022 mem_rvalid in the timeout cycle SHALL take precedence: normal response, bus_err=0.
REQ-023 Minimum latency: gnt in cycle N, mem_req in N+1, owner rvalid no earlier than N+2; next grant no earlier than the cycle after rvalid.

Reset
REQ-024 rst_n=1 SHALL force IDLE, clear counter and owner, set last-winner to IF, drive all outputs 0 in the following cycle.
REQ-025 Reset mid-transaction SHALL abandon it with no rvalid to the owner; later stale mem_rvalid ignored per REQ-020.

Configuration
REQ-026 Macro MEM_ARB_RR_EN defined: on simultaneous requests, grant the requester not granted last (round-robin).
REQ-027 MEM_ARB_RR_EN undefined: fixed priority, LS always wins simultaneous requests; last-winner register absent.

Structure
REQ-028 Package mem_arb_pkg SHALL hold the state enum (IDLE/REQ/WAIT), owner enum (OWN_IF/OWN_LS) and default parameter constants.
REQ-029 Winner selection SHALL be sub-module mem_arb_pick (inputs if_req, ls_req, last winner; output winner, valid).

Verification
REQ-030 IF only, addr 0x10, mem_gnt immediate, mem_rvalid next cycle data 0x00500093 -> if_gnt cycle 0, mem_req cycle 1, if_rvalid cycle 2 with 0x00500093.
REQ-031 LS write addr 0x40, wdata 0xDEADBEEF, be 0xF, mem_gnt delayed 3 cycles -> mem_req held 3 cycles with stable fields, ls_rvalid after mem_rvalid, if_rvalid 0.
REQ-032 Both request every cycle, 4 transactions -> RR build: LS, IF, LS, IF; fixed build: LS x4, IF starved.
REQ-033 TIMEOUT=4, no mem_rvalid -> owner rvalid, rdata 0, bus_err 1 on 4th WAIT cycle, then IDLE.
REQ-034 rst_n asserted in WAIT, mem_rvalid after reset release -> no rvalid, no bus_err, mem_req 0.
